attack_sequencer: RTL and testbench
===================================

// Module: attack_sequencer
// PURPOSE
//   Frame-synchronous controller sequencing the character attack animation: turns a button
//   press into NONE->STARTUP->ACTIVE->RECOVERY->NONE, one step per frame-count expiry.
//   Drives attack_phase of the character renderer/mixer path and exposes hitbox status to
//   game logic. Phase changes only on frame_tick (vblank), so a frame never mixes phases.
// PARAMETERS
//   CNT_W           8   width of frame counter
//   STARTUP_FRAMES  4   frames spent in STARTUP (1..2**CNT_W)
//   ACTIVE_FRAMES   3   frames spent in ACTIVE  (1..2**CNT_W)
//   RECOVERY_FRAMES 6   frames spent in RECOVERY (1..2**CNT_W)
// PORTS
//   clk            in   1  system clock; the only clock
//   rst            in   1  synchronous, active-high reset
//   frame_tick     in   1  1-cycle pulse at start of vblank, once per frame
//   attack_btn     in   1  attack button level, already synchronised to clk
//   cancel         in   1  1-cycle pulse: abort attack (hit-stun etc.)
//   attack_phase   out  2  00 NONE, 01 STARTUP, 10 ACTIVE, 11 RECOVERY (registered)
//   hitbox_active  out  1  1 iff attack_phase==ACTIVE (registered, same edge)
//   busy           out  1  1 iff attack_phase!=NONE (registered)
//   attack_done    out  1  1-cycle pulse on normal completion of RECOVERY
// BEHAVIOUR
//   - Reset: attack_phase=00, hitbox_active=0, busy=0, attack_done=0, counter=0,
//     btn_prev=0, pending=0, buffered=0. rst mid-attack returns to NONE next edge, no done.
//   - press = attack_btn & ~btn_prev; btn_prev registered every cycle. Held button = 1 press.
//   - NONE: press sets pending. On frame_tick with (pending|press): ->STARTUP,
//     counter<=STARTUP_FRAMES-1, pending<=0. Press and tick in same cycle start that tick.
//   - Non-NONE state on frame_tick: counter!=0 -> decrement; counter==0 -> advance:
//     STARTUP->ACTIVE (load ACTIVE_FRAMES-1), ACTIVE->RECOVERY (load RECOVERY_FRAMES-1),
//     RECOVERY->NONE with attack_done=1 for exactly that next cycle.
//   - Each phase therefore spans exactly its *_FRAMES ticks; outputs update on the edge
//     after the frame_tick cycle (1-cycle latency), stable until next tick.
//   - Presses while STARTUP/ACTIVE ignored (not stored). RECOVERY: see CONFIGURATION.
//   - Non-tick cycles: state and counter hold.
//   - cancel: highest priority after rst, any cycle, any state -> NONE next edge;
//     clears counter, pending, buffered; attack_done stays 0. cancel+press same cycle:
//     press discarded.
//   - Counter arithmetic unsigned CNT_W bits; loads use param-1, never wraps below 0.
// CONFIGURATION
//   ATTACK_BUFFER_EN defined: press during RECOVERY sets buffered; at the RECOVERY-expiry
//     tick, if buffered (or press that cycle), go directly RECOVERY->STARTUP, load
//     STARTUP_FRAMES-1, clear buffered; attack_done still pulses. Only one press buffered.
//   ATTACK_BUFFER_EN undefined: presses during RECOVERY ignored; buffered absent.
// STRUCTURE
//   - Shared package game_pkg: attack phase encoding constants PH_NONE=2'b00,
//     PH_STARTUP=2'b01, PH_ACTIVE=2'b10, PH_RECOVERY=2'b11 (also used by renderer).
//   - Sub-module btn_edge_detect (clk, rst, level -> 1-cycle rise pulse); FSM + counter
//     stay in this module.
// TESTING (defaults, frame_tick every 10 cycles)
//   1. rst high 2 cycles, inputs toggling -> all outputs 0 throughout and after release.
//   2. Single press in NONE -> phase 01 for 4 ticks, 10 for 3, 11 for 6, then 00;
//      hitbox_active high exactly 30 cycles; attack_done high 1 cycle at return to 00.
//   3. attack_btn held 200 cycles -> exactly one attack sequence, no restart.
//   4. cancel on 2nd ACTIVE frame -> phase 00 next edge, attack_done never pulses; new
//      press afterwards starts normally. Same for rst mid-ACTIVE.
//   5. Press on 3rd RECOVERY frame -> undefined macro: ends in 00, no restart; with
//      ATTACK_BUFFER_EN: 11->01 at expiry tick, attack_done pulses, busy stays 1.
//   6. Press coincident with frame_tick in NONE -> phase 01 on next edge; press between
//      ticks -> phase 01 only after following tick.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: attack phase encoding shared by the sequencer and the renderer/mixer path
package game_pkg;
  typedef enum logic [1:0] {
    PH_NONE     = 2'b00,
    PH_STARTUP  = 2'b01,
    PH_ACTIVE   = 2'b10,
    PH_RECOVERY = 2'b11
  } phase_e;
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: one-cycle pulse on each rising edge of a synchronised level
// Ports: clk, rst (sync active-high), level (input level), rise (1-cycle rise pulse)
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : level;
  assign rise = level & ~prev_q;
endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer: frame-synchronous NONE->STARTUP->ACTIVE->RECOVERY->NONE attack controller
// Ports: clk, rst (sync active-high), frame_tick (vblank pulse), attack_btn (level),
//   cancel (abort pulse) -> attack_phase, hitbox_active, busy, attack_done (1-cycle pulse)
// Option: ATTACK_BUFFER_EN buffers one press during RECOVERY to chain straight into STARTUP
module attack_sequencer
  import game_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 3,
  parameter int RECOVERY_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       attack_btn,
  input  logic       cancel,
  output logic [1:0] attack_phase,
  output logic       hitbox_active,
  output logic       busy,
  output logic       attack_done
);
  localparam logic [CNT_W-1:0] LD_S = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] LD_A = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] LD_R = CNT_W'(RECOVERY_FRAMES - 1);
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d, done_q, done_d, hit_q, busy_q, press;
`ifdef ATTACK_BUFFER_EN
  logic             buf_q, buf_d;
`endif
  btn_edge_detect u_edge (.clk(clk), .rst(rst), .level(attack_btn), .rise(press));
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
`ifdef ATTACK_BUFFER_EN
    buf_d   = buf_q;
`endif
    if (cancel) begin
      phase_d = PH_NONE;
      cnt_d   = '0;
      pend_d  = 1'b0;
`ifdef ATTACK_BUFFER_EN
      buf_d   = 1'b0;
`endif
    end else if (phase_q == PH_NONE) begin
      if (frame_tick && (pend_q || press)) begin
        phase_d = PH_STARTUP;
        cnt_d   = LD_S;
        pend_d  = 1'b0;
      end else if (press) pend_d = 1'b1;
    end else begin
`ifdef ATTACK_BUFFER_EN
      if (phase_q == PH_RECOVERY && press) buf_d = 1'b1;
`endif
      if (frame_tick) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (phase_q == PH_STARTUP) begin
          phase_d = PH_ACTIVE;
          cnt_d   = LD_A;
        end else if (phase_q == PH_ACTIVE) begin
          phase_d = PH_RECOVERY;
          cnt_d   = LD_R;
        end else begin
          done_d  = 1'b1;
          phase_d = PH_NONE;
`ifdef ATTACK_BUFFER_EN
          // a press landing on the expiry tick itself also chains
          if (buf_q || press) begin
            phase_d = PH_STARTUP;
            cnt_d   = LD_S;
            buf_d   = 1'b0;
          end
`endif
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_NONE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      buf_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      hit_q   <= phase_d == PH_ACTIVE;
      busy_q  <= phase_d != PH_NONE;
`ifdef ATTACK_BUFFER_EN
      buf_q   <= buf_d;
`endif
    end
  end
  assign attack_phase  = phase_q;
  assign hitbox_active = hit_q;
  assign busy          = busy_q;
  assign attack_done   = done_q;
endmodule

// File: tb/tb_attack_sequencer.sv
// tb_attack_sequencer: directed self-checking bench, frame_tick every 10 cycles
module tb_attack_sequencer;
  logic clk = 0, rst = 1, frame_tick = 0, attack_btn = 0, cancel = 0;
  logic [1:0] attack_phase;
  logic hitbox_active, busy, attack_done;
  int tcnt = 0, checks = 0, fails = 0;
  int ph_cyc[4];
  int done_cnt, starts, rec_to_st, busy_drops, inv_bad;
  logic [1:0] prev_ph = 2'b00;

  attack_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .attack_btn(attack_btn), .cancel(cancel),
    .attack_phase(attack_phase), .hitbox_active(hitbox_active), .busy(busy), .attack_done(attack_done)
  );

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic c, input logic r);
    @(negedge clk);
    frame_tick = (tcnt == 0);
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    attack_btn = b;
    cancel = c;
    rst = r;
    @(posedge clk);
    #1;
    ph_cyc[attack_phase]++;
    if (attack_done) done_cnt++;
    if (attack_phase == 2'b01 && prev_ph != 2'b01) starts++;
    if (attack_phase == 2'b01 && prev_ph == 2'b11) rec_to_st++;
    if (prev_ph != 2'b00 && !busy) busy_drops++;
    if (hitbox_active !== (attack_phase == 2'b10) || busy !== (attack_phase != 2'b00) ||
        (attack_done && attack_phase != 2'b00)) inv_bad++;
    prev_ph = attack_phase;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic clear();
    for (int i = 0; i < 4; i++) ph_cyc[i] = 0;
    done_cnt = 0; starts = 0; rec_to_st = 0; busy_drops = 0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    int n = 0;
    while (attack_phase !== p && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    checks++;
    if (attack_phase !== p) begin
      fails++;
      $display("FAIL wait_phase: phase=%b required=%b within %0d cycles", attack_phase, p, budget);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({attack_phase, hitbox_active, busy, attack_done} !== 5'b0) begin
      fails++;
      $display("FAIL %s: phase=%b hit=%b busy=%b done=%b required all 0",
               name, attack_phase, hitbox_active, busy, attack_done);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 1);
    check_idle("reset_cycle1");
    step(0, 1, 1);
    check_idle("reset_cycle2");
    step(0, 0, 0);
    check_idle("reset_release");
  endtask

  task automatic test_single();
    idle(5);
    clear();
    step(1, 0, 0);
    idle(200);
    checks++;
    if (ph_cyc[1] != 40 || ph_cyc[2] != 30 || ph_cyc[3] != 60) begin
      fails++;
      $display("FAIL single_phase_len: startup=%0d active=%0d recovery=%0d required 40/30/60",
               ph_cyc[1], ph_cyc[2], ph_cyc[3]);
    end
    checks++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL single_done: done cycles=%0d required 1", done_cnt);
    end
    check_idle("single_end");
  endtask

  task automatic test_held();
    clear();
    for (int i = 0; i < 200; i++) step(1, 0, 0);
    idle(50);
    checks++;
    if (starts != 1 || done_cnt != 1) begin
      fails++;
      $display("FAIL held_button: starts=%0d done=%0d required 1/1", starts, done_cnt);
    end
    check_idle("held_end");
  endtask

  task automatic test_cancel();
    step(1, 0, 0);
    wait_phase(2'b10, 100);
    idle(12);
    clear();
    step(0, 1, 0);
    check_idle("cancel_next_edge");
    idle(150);
    checks++;
    if (done_cnt != 0 || starts != 0) begin
      fails++;
      $display("FAIL cancel_no_done: done=%0d starts=%0d required 0/0", done_cnt, starts);
    end
    clear();
    step(1, 0, 0);
    idle(200);
    checks++;
    if (starts != 1 || done_cnt != 1 || ph_cyc[2] != 30) begin
      fails++;
      $display("FAIL cancel_restart: starts=%0d done=%0d active=%0d required 1/1/30",
               starts, done_cnt, ph_cyc[2]);
    end
    step(1, 0, 0);
    wait_phase(2'b10, 100);
    idle(12);
    clear();
    step(0, 0, 1);
    check_idle("rst_mid_active");
    idle(150);
    checks++;
    if (done_cnt != 0) begin
      fails++;
      $display("FAIL rst_no_done: done=%0d required 0", done_cnt);
    end
    clear();
    step(1, 0, 0);
    idle(200);
    checks++;
    if (starts != 1 || done_cnt != 1) begin
      fails++;
      $display("FAIL rst_restart: starts=%0d done=%0d required 1/1", starts, done_cnt);
    end
  endtask

  task automatic test_recovery_press();
    step(1, 0, 0);
    wait_phase(2'b11, 200);
    idle(22);
    clear();
    step(1, 0, 0);
    idle(200);
`ifdef ATTACK_BUFFER_EN
    checks++;
    if (rec_to_st != 1 || done_cnt != 2 || busy_drops != 1) begin
      fails++;
      $display("FAIL buffered_chain: rec_to_st=%0d done=%0d busy_drops=%0d required 1/2/1",
               rec_to_st, done_cnt, busy_drops);
    end
`else
    checks++;
    if (starts != 0 || done_cnt != 1 || busy_drops != 1) begin
      fails++;
      $display("FAIL recovery_ignored: starts=%0d done=%0d busy_drops=%0d required 0/1/1",
               starts, done_cnt, busy_drops);
    end
`endif
    check_idle("recovery_end");
  endtask

  task automatic test_tick_alignment();
    int early = 0;
    while (tcnt != 0) step(0, 0, 0);
    step(1, 0, 0);
    checks++;
    if (attack_phase !== 2'b01) begin
      fails++;
      $display("FAIL press_on_tick: phase=%b required 01", attack_phase);
    end
    step(0, 1, 0);
    check_idle("cancel_after_tick_start");
    while (tcnt != 3) step(0, 0, 0);
    step(1, 0, 0);
    while (tcnt != 0) begin
      step(0, 0, 0);
      if (attack_phase !== 2'b00) early++;
    end
    checks++;
    if (early != 0) begin
      fails++;
      $display("FAIL press_between_early: cycles non-NONE before tick=%0d required 0", early);
    end
    step(0, 0, 0);
    checks++;
    if (attack_phase !== 2'b01) begin
      fails++;
      $display("FAIL press_between_tick: phase=%b required 01", attack_phase);
    end
    idle(200);
    check_idle("alignment_end");
  endtask

  initial begin
    inv_bad = 0;
    clear();
    test_reset();
    test_single();
    test_held();
    test_cancel();
    test_recovery_press();
    test_tick_alignment();
    checks++;
    if (inv_bad != 0) begin
      fails++;
      $display("FAIL output_consistency: bad cycles=%0d required 0", inv_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
